// File: rtl/ifu_inst_mem_responder_if.sv
// IFU fetch handshake plus instruction-memory read port, bundled for the responder.
// The slave modport is the responder's view; the master modport drives it (IFU + memory).
interface ifu_inst_mem_responder_if #(
  parameter int BITS_W = 32,
  parameter int INST_W = 32
);
  logic [BITS_W-1:0] ifu_pc;
  logic              ifu_pc_valid;
  logic              ifu_pc_ready;
  logic [INST_W-1:0] ifu_inst;
  logic              ifu_inst_valid;
  logic              ifu_inst_ready;
  logic              ifu_inst_err;
  logic              flush;
  logic              mem_req;
  logic [BITS_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [INST_W-1:0] mem_rdata;
  logic              mem_rerr;

  modport slave (
    input  ifu_pc, ifu_pc_valid, ifu_inst_ready, flush,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
    output ifu_pc_ready, ifu_inst, ifu_inst_valid, ifu_inst_err,
    output mem_req, mem_addr
  );

  modport master (
    output ifu_pc, ifu_pc_valid, ifu_inst_ready, flush,
    output mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
    input  ifu_pc_ready, ifu_inst, ifu_inst_valid, ifu_inst_err,
    input  mem_req, mem_addr
  );
endinterface

// File: rtl/ifu_inst_mem_responder.sv
// Memory-side responder for IFU fetches: one PC in, one memory read, one instruction out,
// with flush, address-window checking and a grant-to-data timeout.
module ifu_inst_mem_responder #(
  parameter int                BITS_W    = 32,
  parameter int                INST_W    = 32,
  parameter logic [BITS_W-1:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [BITS_W-1:0] ADDR_SIZE = 32'h0800_0000,
  parameter int                TIMEOUT   = 255
) (
  input logic                      clk,
  input logic                      rst,
  ifu_inst_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [BITS_W-1:0] r_pc, w_pc_nxt;
  logic [INST_W-1:0] r_inst, w_inst_nxt;
  logic              r_err, w_err_nxt;
  logic              r_drop, w_drop_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;

  logic [BITS_W:0]   w_off;
  logic              w_illegal;
  logic [16:0]       w_cnt_inc;
  logic              w_tmo;

  // One extra bit keeps the window offset from wrapping for PCs near the top of the space.
  assign w_off     = {1'b0, bus.ifu_pc} - {1'b0, ADDR_BASE};
  assign w_illegal = (|bus.ifu_pc[1:0]) || (bus.ifu_pc < ADDR_BASE) ||
                     (w_off >= {1'b0, ADDR_SIZE});

  // w_cnt_inc counts WAIT cycles including the current one.
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
  assign w_tmo     = (w_cnt_inc == 17'(TIMEOUT));

  assign bus.ifu_pc_ready   = (r_state == IDLE);
  assign bus.mem_req        = (r_state == REQ);
  assign bus.mem_addr       = r_pc;
  assign bus.ifu_inst_valid = (r_state == RESP);
  assign bus.ifu_inst       = r_inst;
  assign bus.ifu_inst_err   = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_err_nxt   = r_err;
    w_drop_nxt  = r_drop;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.ifu_pc_valid) begin
          w_pc_nxt = bus.ifu_pc;
          if (w_illegal) begin
            w_state_nxt = RESP;
            w_inst_nxt  = '0;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        // The request cannot be withdrawn, so a flush here is remembered until the data returns.
        if (bus.flush) w_drop_nxt = 1'b1;
        if (bus.mem_gnt) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = '0;
        end
      end
      WAIT: begin
        w_cnt_nxt = w_cnt_inc[15:0];
        if (bus.flush) w_drop_nxt = 1'b1;
        if (bus.mem_rvalid || w_tmo) begin
          if (bus.flush || r_drop) begin
            w_state_nxt = IDLE;
            w_drop_nxt  = 1'b0;
          end else begin
            w_state_nxt = RESP;
            w_inst_nxt  = bus.mem_rvalid ? bus.mem_rdata : '0;
            w_err_nxt   = bus.mem_rvalid ? bus.mem_rerr  : 1'b1;
          end
        end
      end
      RESP: begin
        if (bus.ifu_inst_ready || bus.flush) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_inst  <= '0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_err   <= w_err_nxt;
      r_drop  <= w_drop_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ifu_inst_mem_responder.sv
// Directed bench for ifu_inst_mem_responder: inputs change and outputs are checked on the falling edge.
module tb_ifu_inst_mem_responder;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ifu_inst_mem_responder_if #(.BITS_W(32), .INST_W(32)) bus ();

  ifu_inst_mem_responder #(.TIMEOUT(TMO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full legal fetch: accept in cycle 0, grant after gdly REQ cycles, data one cycle later.
  task automatic fetch(input logic [31:0] pc, input int gdly, input logic [31:0] rdata,
                       input logic rerr, input logic fl, input string tag);
    check({tag, "_pc_ready"}, 32'(bus.ifu_pc_ready), 32'd1);
    bus.ifu_pc = pc; bus.ifu_pc_valid = 1'b1; bus.flush = fl;
    step();
    bus.ifu_pc_valid = 1'b0; bus.flush = 1'b0;
    for (int i = 0; i < gdly; i++) begin
      check({tag, "_req_hold"}, 32'(bus.mem_req), 32'd1);
      step();
    end
    check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
    check({tag, "_addr"}, bus.mem_addr, pc);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check({tag, "_wait_nv"}, 32'(bus.ifu_inst_valid), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata; bus.mem_rerr = rerr;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rerr = 1'b0;
    check({tag, "_valid"}, 32'(bus.ifu_inst_valid), 32'd1);
    check({tag, "_inst"}, bus.ifu_inst, rdata);
    check({tag, "_err"}, 32'(bus.ifu_inst_err), 32'(rerr));
    step();
    check({tag, "_done_nv"}, 32'(bus.ifu_inst_valid), 32'd0);
    check({tag, "_done_rdy"}, 32'(bus.ifu_pc_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] bad_pc [3];
    bad_pc[0] = 32'h8000_0002; bad_pc[1] = 32'h7FFF_FFFC; bad_pc[2] = 32'h8800_0000;

    bus.ifu_pc = '0; bus.ifu_pc_valid = 1'b0; bus.ifu_inst_ready = 1'b1; bus.flush = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_rerr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    check("rst_pc_ready", 32'(bus.ifu_pc_ready), 32'd1);
    check("rst_valid", 32'(bus.ifu_inst_valid), 32'd0);
    check("rst_inst", bus.ifu_inst, 32'd0);
    check("rst_err", 32'(bus.ifu_inst_err), 32'd0);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);

    fetch(32'h8000_0000, 0, 32'h0000_0413, 1'b0, 1'b0, "basic");

    // Slow grant and response backpressure.
    bus.ifu_pc = 32'h8000_0010; bus.ifu_pc_valid = 1'b1;
    step();
    bus.ifu_pc_valid = 1'b0;
    repeat (3) begin
      check("bp_req", 32'(bus.mem_req), 32'd1);
      check("bp_addr", bus.mem_addr, 32'h8000_0010);
      step();
    end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF; bus.ifu_inst_ready = 1'b0;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (4) begin
      check("bp_valid", 32'(bus.ifu_inst_valid), 32'd1);
      check("bp_inst", bus.ifu_inst, 32'hDEAD_BEEF);
      check("bp_err", 32'(bus.ifu_inst_err), 32'd0);
      step();
    end
    bus.ifu_inst_ready = 1'b1;
    check("bp_valid_last", 32'(bus.ifu_inst_valid), 32'd1);
    step();
    check("bp_one_resp", 32'(bus.ifu_inst_valid), 32'd0);
    check("bp_pc_ready", 32'(bus.ifu_pc_ready), 32'd1);

    // Illegal PCs answer in cycle 1 without touching memory.
    for (int i = 0; i < 3; i++) begin
      bus.ifu_pc = bad_pc[i]; bus.ifu_pc_valid = 1'b1;
      step();
      bus.ifu_pc_valid = 1'b0;
      check("ill_valid", 32'(bus.ifu_inst_valid), 32'd1);
      check("ill_err", 32'(bus.ifu_inst_err), 32'd1);
      check("ill_inst", bus.ifu_inst, 32'd0);
      check("ill_noreq", 32'(bus.mem_req), 32'd0);
      step();
      check("ill_done", 32'(bus.ifu_pc_ready), 32'd1);
      check("ill_noreq2", 32'(bus.mem_req), 32'd0);
    end

    fetch(32'h87FF_FFFC, 1, 32'h0010_0093, 1'b0, 1'b0, "top_word");

    // Flush while the request is pending: data arrives but no response follows.
    bus.ifu_pc = 32'h8000_0200; bus.ifu_pc_valid = 1'b1;
    step();
    bus.ifu_pc_valid = 1'b0; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flreq_req_held", 32'(bus.mem_req), 32'd1);
    step();
    check("flreq_req_held2", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_1111;
    step();
    bus.mem_rvalid = 1'b0;
    check("flreq_noresp", 32'(bus.ifu_inst_valid), 32'd0);
    check("flreq_idle", 32'(bus.ifu_pc_ready), 32'd1);

    // Flush while the response waits for ready.
    bus.ifu_pc = 32'h8000_0300; bus.ifu_pc_valid = 1'b1;
    step();
    bus.ifu_pc_valid = 1'b0; bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h2222_2222; bus.ifu_inst_ready = 1'b0;
    step();
    bus.mem_rvalid = 1'b0;
    check("flresp_valid", 32'(bus.ifu_inst_valid), 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flresp_drop", 32'(bus.ifu_inst_valid), 32'd0);
    check("flresp_idle", 32'(bus.ifu_pc_ready), 32'd1);

    // Flush during an illegal-PC response.
    bus.ifu_pc = 32'h8000_0001; bus.ifu_pc_valid = 1'b1;
    step();
    bus.ifu_pc_valid = 1'b0;
    check("flill_valid", 32'(bus.ifu_inst_valid), 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.ifu_inst_ready = 1'b1;
    check("flill_drop", 32'(bus.ifu_inst_valid), 32'd0);

    fetch(32'h8000_0400, 0, 32'h0000_0513, 1'b0, 1'b1, "flidle");

    // Timeout: no rvalid after grant gives an error response 4 cycles after WAIT entry.
    bus.ifu_pc = 32'h8000_0100; bus.ifu_pc_valid = 1'b1;
    step();
    bus.ifu_pc_valid = 1'b0; bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0; bus.ifu_inst_ready = 1'b0;
    repeat (TMO) begin
      check("tmo_wait", 32'(bus.ifu_inst_valid), 32'd0);
      step();
    end
    check("tmo_valid", 32'(bus.ifu_inst_valid), 32'd1);
    check("tmo_err", 32'(bus.ifu_inst_err), 32'd1);
    check("tmo_inst", bus.ifu_inst, 32'd0);
    bus.ifu_inst_ready = 1'b1;
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
    step();
    bus.mem_rvalid = 1'b0;
    check("tmo_late_rv", 32'(bus.ifu_inst_valid), 32'd0);
    fetch(32'h8000_0104, 0, 32'h0020_0113, 1'b0, 1'b0, "after_tmo");

    fetch(32'h8000_0500, 0, 32'h1234_5678, 1'b1, 1'b0, "buserr");

    // Asynchronous reset while waiting for data.
    bus.ifu_pc = 32'h8000_0600; bus.ifu_pc_valid = 1'b1;
    step();
    bus.ifu_pc_valid = 1'b0; bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check("rw_pre_req", 32'(bus.mem_req), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rw_pc_ready", 32'(bus.ifu_pc_ready), 32'd1);
    check("rw_req", 32'(bus.mem_req), 32'd0);
    check("rw_addr", bus.mem_addr, 32'd0);
    check("rw_valid", 32'(bus.ifu_inst_valid), 32'd0);
    check("rw_inst", bus.ifu_inst, 32'd0);
    check("rw_err", 32'(bus.ifu_inst_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rw_after", 32'(bus.ifu_pc_ready), 32'd1);
    fetch(32'h8000_0700, 0, 32'h0030_0193, 1'b0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
